alu_packet_ctrl: RTL and testbench

//  Packet sequencer between the UART byte streams and the alu datapath. Parses each RX

---
 rtl/alu_packet_ctrl_if.sv | 31 +++
 rtl/alu_packet_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_alu_packet_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_packet_ctrl_if.sv
// Byte-stream and alu handshake bundle for alu_packet_ctrl.
// master = the controller, slave = the surrounding uart/alu logic.
interface alu_packet_ctrl_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic        rx_ready_o;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic [7:0]  alu_opcode_o;
   logic [31:0] alu_data1_o;
   logic [31:0] alu_data2_o;
   logic        alu_data1_valid_o;
   logic        alu_data2_valid_o;
   logic        alu_start_o;
   logic [63:0] alu_data_i;
   logic        alu_valid_i;
   logic        err_o;

   modport master (
      input  rx_data_i, rx_valid_i, tx_ready_i, alu_data_i, alu_valid_i,
      output rx_ready_o, tx_data_o, tx_valid_o, alu_opcode_o, alu_data1_o, alu_data2_o,
             alu_data1_valid_o, alu_data2_valid_o, alu_start_o, err_o
   );

   modport slave (
      output rx_data_i, rx_valid_i, tx_ready_i, alu_data_i, alu_valid_i,
      input  rx_ready_o, tx_data_o, tx_valid_o, alu_opcode_o, alu_data1_o, alu_data2_o,
             alu_data1_valid_o, alu_data2_valid_o, alu_start_o, err_o
   );
endinterface

// File: rtl/alu_packet_ctrl.sv
// Packet sequencer: parses RX packets, echoes payloads or sums 32-bit LE operands on the
// alu, and streams the 4-byte result to TX.
module alu_packet_ctrl #(
   parameter logic [7:0]  OP_ECHO = 8'hEC,
   parameter logic [7:0]  OP_ADD  = 8'hAD,
   parameter logic [15:0] MAX_LEN = 16'hFFFF
) (
   input logic             clk,
   input logic             rst,
   alu_packet_ctrl_if.master bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] HDR    = 3'd1;
   localparam logic [2:0] ECHO   = 3'd2;
   localparam logic [2:0] GATHER = 3'd3;
   localparam logic [2:0] ISSUE  = 3'd4;
   localparam logic [2:0] SEND   = 3'd5;
   localparam logic [2:0] DRAIN  = 3'd6;

   logic [2:0]  state_q, state_d;
   logic [7:0]  opcode_q, opcode_d;
   logic [1:0]  hdr_cnt_q, hdr_cnt_d;
   logic [7:0]  len_lo_q, len_lo_d;
   logic [15:0] rem_q, rem_d;
   logic [31:0] opnd_q, opnd_d;
   logic [1:0]  byte_cnt_q, byte_cnt_d;
   logic        first_q, first_d;
   logic [31:0] acc_q, acc_d;
   logic [1:0]  idx_q, idx_d;
   logic        err_q, err_d;

   logic        rx_ready;
   logic        rx_fire;
   logic [15:0] len_raw, len_clamp, plen;
   logic        tail;
   logic [31:0] opnd_shift;
   logic        unused_alu_hi;

   assign unused_alu_hi = ^bus.alu_data_i[63:32];

   assign len_raw    = {bus.rx_data_i, len_lo_q};
   assign len_clamp  = (len_raw > MAX_LEN) ? MAX_LEN : len_raw;
   assign plen       = (len_clamp < 16'd4) ? 16'd0 : len_clamp - 16'd4;
   // A byte starting an operand with fewer than 4 bytes left belongs to the discarded tail.
   assign tail       = (byte_cnt_q == 2'd0) && (rem_q < 16'd4);
   assign opnd_shift = {bus.rx_data_i, opnd_q[31:8]};
   assign rx_fire    = bus.rx_valid_i && rx_ready;

   always_comb begin
      rx_ready              = 1'b0;
      bus.tx_valid_o        = 1'b0;
      bus.tx_data_o         = 8'h00;
      bus.alu_opcode_o      = 8'h00;
      bus.alu_data1_o       = 32'h0;
      bus.alu_data2_o       = 32'h0;
      bus.alu_data1_valid_o = 1'b0;
      bus.alu_data2_valid_o = 1'b0;
      bus.alu_start_o       = 1'b0;
      case (state_q)
         IDLE, HDR, GATHER, DRAIN: rx_ready = 1'b1;
         ECHO: begin
            rx_ready       = bus.tx_ready_i;
            bus.tx_valid_o = bus.rx_valid_i;
            bus.tx_data_o  = bus.rx_data_i;
         end
         ISSUE: begin
            bus.alu_opcode_o      = OP_ADD;
            bus.alu_data1_o       = acc_q;
            bus.alu_data2_o       = opnd_q;
            bus.alu_data1_valid_o = 1'b1;
            bus.alu_data2_valid_o = 1'b1;
            bus.alu_start_o       = 1'b1;
         end
         SEND: begin
            bus.tx_valid_o = 1'b1;
            bus.tx_data_o  = acc_q[{idx_q, 3'b000} +: 8];
         end
         default: ;
      endcase
   end

   assign bus.rx_ready_o = rx_ready;
   assign bus.err_o      = err_q;

   always_comb begin
      state_d    = state_q;
      opcode_d   = opcode_q;
      hdr_cnt_d  = hdr_cnt_q;
      len_lo_d   = len_lo_q;
      rem_d      = rem_q;
      opnd_d     = opnd_q;
      byte_cnt_d = byte_cnt_q;
      first_d    = first_q;
      acc_d      = acc_q;
      idx_d      = idx_q;
      err_d      = 1'b0;
      case (state_q)
         IDLE: if (rx_fire) begin
            opcode_d  = bus.rx_data_i;
            first_d   = 1'b1;
            hdr_cnt_d = 2'd0;
            state_d   = HDR;
         end
         HDR: if (rx_fire) begin
            hdr_cnt_d = hdr_cnt_q + 2'd1;
            if (hdr_cnt_q == 2'd1) len_lo_d = bus.rx_data_i;
            if (hdr_cnt_q == 2'd2) begin
               rem_d      = plen;
               byte_cnt_d = 2'd0;
               opnd_d     = 32'h0;
               if (len_clamp < 16'd4) err_d = 1'b1;
               if (plen == 16'd0) begin
                  state_d = (opcode_q == OP_ADD) ? SEND : IDLE;
               end else if (opcode_q == OP_ECHO) begin
                  state_d = ECHO;
               end else if (opcode_q == OP_ADD) begin
                  state_d = GATHER;
               end else begin
                  state_d = DRAIN;
                  err_d   = 1'b1;
               end
            end
         end
         ECHO, DRAIN: if (rx_fire) begin
            rem_d = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = IDLE;
         end
         GATHER: if (rx_fire) begin
            rem_d = rem_q - 16'd1;
            if (tail) begin
               if (rem_q == 16'd1) begin
                  err_d   = 1'b1;
                  state_d = SEND;
               end
            end else begin
               opnd_d     = opnd_shift;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  if (first_q) begin
                     acc_d   = opnd_shift;
                     first_d = 1'b0;
                     if (rem_q == 16'd1) state_d = SEND;
                  end else begin
                     state_d = ISSUE;
                  end
               end
            end
         end
         ISSUE: if (bus.alu_valid_i) begin
            acc_d   = bus.alu_data_i[31:0];
            state_d = (rem_q == 16'd0) ? SEND : GATHER;
         end
         SEND: if (bus.tx_ready_i) begin
            idx_d = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               acc_d   = 32'h0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         opcode_q   <= 8'h00;
         hdr_cnt_q  <= 2'd0;
         len_lo_q   <= 8'h00;
         rem_q      <= 16'h0;
         opnd_q     <= 32'h0;
         byte_cnt_q <= 2'd0;
         first_q    <= 1'b0;
         acc_q      <= 32'h0;
         idx_q      <= 2'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         opcode_q   <= opcode_d;
         hdr_cnt_q  <= hdr_cnt_d;
         len_lo_q   <= len_lo_d;
         rem_q      <= rem_d;
         opnd_q     <= opnd_d;
         byte_cnt_q <= byte_cnt_d;
         first_q    <= first_d;
         acc_q      <= acc_d;
         idx_q      <= idx_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_alu_packet_ctrl.sv
// Directed bench for alu_packet_ctrl with a behavioural combinational adder as the alu.
module tb_alu_packet_ctrl;
   typedef logic [7:0] byte_q_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic alu_en = 1'b1;
   logic tx_toggle = 1'b0;
   logic tx_rdy = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   err_cnt = 0;
   int   start_cnt = 0;
   logic start_prev = 1'b0;
   logic [7:0] tx_log[$];

   alu_packet_ctrl_if bus();

   alu_packet_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Upper result half is junk so any use of it shows up in the sums.
   assign bus.alu_valid_i = bus.alu_start_o && alu_en;
   assign bus.alu_data_i  = {32'hDEAD_BEEF, bus.alu_data1_o + bus.alu_data2_o};
   assign bus.tx_ready_i  = tx_rdy;

   always @(posedge clk) begin
      #2;
      if (rst || !tx_toggle) tx_rdy = 1'b1;
      else tx_rdy = ~tx_rdy;
   end

   // Observe just before each rising edge, when every input is settled.
   always @(negedge clk) begin
      #4;
      if (!rst) begin
         if (bus.tx_valid_o && bus.tx_ready_i) tx_log.push_back(bus.tx_data_o);
         if (bus.err_o) err_cnt <= err_cnt + 1;
         if (bus.alu_start_o && !start_prev) start_cnt <= start_cnt + 1;
      end
      start_prev <= bus.alu_start_o;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bus.rx_data_i  = b;
      bus.rx_valid_i = 1'b1;
      while (!bus.rx_ready_o && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("rx_accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask

   task automatic send_pkt(input byte_q_t p);
      foreach (p[i]) send_byte(p[i]);
      @(negedge clk);
      bus.rx_valid_i = 1'b0;
   endtask

   task automatic run_pkt(input string tag, input byte_q_t p, input byte_q_t exp_tx,
                          input int exp_err, input int exp_starts);
      int b = tx_log.size();
      int e = err_cnt;
      int s = start_cnt;
      int n = 0;
      send_pkt(p);
      while (tx_log.size() < b + exp_tx.size() && n < 60) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_txlen"}, tx_log.size() - b, exp_tx.size());
      foreach (exp_tx[i])
         if (b + i < tx_log.size()) chk($sformatf("%s_tx%0d", tag, i), tx_log[b+i], exp_tx[i]);
      chk({tag, "_err"}, err_cnt - e, exp_err);
      if (exp_starts >= 0) chk({tag, "_starts"}, start_cnt - s, exp_starts);
   endtask

   initial begin
      int b;
      bus.rx_data_i  = 8'h00;
      bus.rx_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", bus.rx_ready_o, 1);
      chk("rst_tx_valid", bus.tx_valid_o, 0);
      chk("rst_alu_start", bus.alu_start_o, 0);
      chk("rst_alu_data1", bus.alu_data1_o, 0);
      chk("rst_err", bus.err_o, 0);
      rst = 1'b0;
      @(negedge clk);

      run_pkt("add", '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                       8'h02, 8'h00, 8'h00, 8'h00}, '{8'h03, 8'h00, 8'h00, 8'h00}, 0, 1);
      run_pkt("wrap", '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                        8'h02, 8'h00, 8'h00, 8'h00}, '{8'h01, 8'h00, 8'h00, 8'h00}, 0, 1);
      tx_toggle = 1'b1;
      run_pkt("echo", '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43},
              '{8'h41, 8'h42, 8'h43}, 0, 0);
      tx_toggle = 1'b0;
      run_pkt("badop", '{8'h5A, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22}, '{}, 1, 0);
      run_pkt("add2", '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                        8'h02, 8'h00, 8'h00, 8'h00}, '{8'h03, 8'h00, 8'h00, 8'h00}, 0, 1);
      run_pkt("odd", '{8'hAD, 8'h00, 8'h06, 8'h00, 8'h05, 8'h06},
              '{8'h00, 8'h00, 8'h00, 8'h00}, 1, 0);
      run_pkt("zero", '{8'hAD, 8'h00, 8'h04, 8'h00}, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 0);
      run_pkt("three_ops", '{8'hAD, 8'h00, 8'h10, 8'h00, 8'h10, 8'h32, 8'h54, 8'h76,
                             8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h80},
              '{8'h11, 8'h33, 8'h55, 8'hF7}, 0, 2);

      // Reset while an alu op is outstanding.
      alu_en = 1'b0;
      b = tx_log.size();
      send_pkt('{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                 8'h02, 8'h00, 8'h00, 8'h00});
      repeat (2) @(negedge clk);
      chk("issue_start", bus.alu_start_o, 1);
      chk("issue_data1", bus.alu_data1_o, 32'h1);
      chk("issue_data2", bus.alu_data2_o, 32'h2);
      chk("issue_opcode", bus.alu_opcode_o, 32'hAD);
      chk("issue_rx_ready", bus.rx_ready_o, 0);
      #1 rst = 1'b1;
      #1;
      chk("midrst_start", bus.alu_start_o, 0);
      chk("midrst_data1", bus.alu_data1_o, 0);
      chk("midrst_rx_ready", bus.rx_ready_o, 1);
      chk("midrst_tx_valid", bus.tx_valid_o, 0);
      @(negedge clk);
      rst = 1'b0;
      alu_en = 1'b1;
      repeat (4) @(negedge clk);
      chk("midrst_no_tx", tx_log.size() - b, 0);
      run_pkt("after_rst", '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00,
                             8'h02, 8'h00, 8'h00, 8'h00}, '{8'h03, 8'h00, 8'h00, 8'h00}, 0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end
endmodule
